// File: rtl/serv_irq_source.sv
// serv_irq_source: memory-mapped interrupt source for the SERV core.
// Provides a 64-bit mtime/mtimecmp machine timer (o_mtip) and an
// edge-latched external interrupt gateway with enable and claim (o_meip),
// behind a single-cycle 32-bit Wishbone slave.
//
// Optional build macro SERV_IRQ_SYNC_EN: when defined, i_irq passes through
// a 2-flop synchronizer before edge detection (edge-to-pending latency 3
// cycles instead of 1). When undefined, i_irq must be synchronous to i_clk.
//
// Register map (word address i_wb_adr):
//   0 mtime[31:0] RW      1 mtime[63:32] RW
//   2 mtimecmp[31:0] RW   3 mtimecmp[63:32] RW
//   4 pending R/W1C       5 enable RW
//   6 claim R             7 reads 0, writes ignored
//
// Bus handshake: the master raises i_wb_cyc and holds it (with we/adr/dat/sel
// stable) until o_wb_ack. o_wb_ack <= i_wb_cyc & !o_wb_ack, so every access
// gets exactly one ack pulse one cycle after cyc, and a held cyc alternates
// ack high/low. Writes and claim side effects land on the clock edge that
// raises o_wb_ack; o_wb_rdt is valid while o_wb_ack is high.
module serv_irq_source #(
    parameter int NUM_IRQ        = 8,
    parameter int PRESCALE       = 1,
    parameter     RESET_STRATEGY = "MINI"
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wb_cyc,
    input  logic               i_wb_we,
    input  logic [2:0]         i_wb_adr,
    input  logic [31:0]        i_wb_dat,
    input  logic [3:0]         i_wb_sel,
    output logic [31:0]        o_wb_rdt,
    output logic               o_wb_ack,
    input  logic [NUM_IRQ-1:0] i_irq,
    output logic               o_mtip,
    output logic               o_meip
);

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    // Control state (always reset)
    logic               ack_q, ack_d;
    logic [15:0]        presc_q, presc_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic               mtip_q, mtip_d;
    logic               meip_q, meip_d;

    // Datapath state (reset only when RESET_STRATEGY != "NONE")
    logic [31:0]        rdt_q, rdt_d;
    logic [63:0]        mtime_q, mtime_d;
    logic [63:0]        mtimecmp_q, mtimecmp_d;

    // Bus decode
    logic               access;
    logic               bus_wr;
    logic               bus_rd;
    logic [31:0]        byte_mask;

    // Gateway / claim helpers
    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] irq_edge;
    logic [NUM_IRQ-1:0] pend_en;
    logic [NUM_IRQ-1:0] claim_oh;
    logic [4:0]         claim_id;
    logic [NUM_IRQ-1:0] pend_clr;
    logic               tick;

`ifdef SERV_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync1_d;
    logic [NUM_IRQ-1:0] sync2_q, sync2_d;

    // Two-stage synchronizer feeding the edge detector
    always_comb begin
        sync1_d = i_irq;
        sync2_d = sync1_q;
        irq_in  = sync2_q;
    end
`else
    // Source levels are already synchronous to i_clk
    always_comb begin
        irq_in = i_irq;
    end
`endif

    // Access decode: only the cycle that raises ack performs the access
    always_comb begin
        access    = i_wb_cyc & ~ack_q;
        bus_wr    = access & i_wb_we;
        bus_rd    = access & ~i_wb_we;
        byte_mask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}},
                     {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
    end

    // Lowest-numbered enabled pending source wins the claim
    always_comb begin
        pend_en  = pending_q & enable_q;
        claim_id = '0;
        claim_oh = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_en[i]) begin
                claim_id    = 5'(i + 1);
                claim_oh    = '0;
                claim_oh[i] = 1'b1;
            end
        end
    end

    // Prescaler, mtime increment/overwrite, mtimecmp writes, timer compare
    always_comb begin
        tick       = (presc_q == PRESC_MAX);
        presc_d    = tick ? 16'd0 : presc_q + 16'd1;
        mtime_d    = mtime_q + {63'd0, tick};
        mtimecmp_d = mtimecmp_q;
        if (bus_wr) begin
            case (i_wb_adr)
                // A bus write to mtime discards this cycle's increment
                3'd0: mtime_d = {mtime_q[63:32],
                                 (mtime_q[31:0] & ~byte_mask) | (i_wb_dat & byte_mask)};
                3'd1: mtime_d = {(mtime_q[63:32] & ~byte_mask) | (i_wb_dat & byte_mask),
                                 mtime_q[31:0]};
                3'd2: mtimecmp_d[31:0]  = (mtimecmp_q[31:0] & ~byte_mask) |
                                          (i_wb_dat & byte_mask);
                3'd3: mtimecmp_d[63:32] = (mtimecmp_q[63:32] & ~byte_mask) |
                                          (i_wb_dat & byte_mask);
                default: ;
            endcase
        end
        mtip_d = (mtime_q >= mtimecmp_q);
    end

    // Edge gateway, W1C/claim clearing (edge set wins), enable writes
    always_comb begin
        irq_prev_d = irq_in;
        irq_edge   = irq_in & ~irq_prev_q;
        pend_clr   = '0;
        if (bus_wr && (i_wb_adr == 3'd4)) begin
            pend_clr = i_wb_dat[NUM_IRQ-1:0] & byte_mask[NUM_IRQ-1:0];
        end
        if (bus_rd && (i_wb_adr == 3'd6)) begin
            pend_clr = claim_oh;
        end
        pending_d = (pending_q & ~pend_clr) | irq_edge;
        enable_d  = enable_q;
        if (bus_wr && (i_wb_adr == 3'd5)) begin
            enable_d = (enable_q & ~byte_mask[NUM_IRQ-1:0]) |
                       (i_wb_dat[NUM_IRQ-1:0] & byte_mask[NUM_IRQ-1:0]);
        end
        meip_d = |pend_en;
    end

    // Acknowledge and read-data capture
    always_comb begin
        ack_d = access;
        rdt_d = rdt_q;
        if (bus_rd) begin
            case (i_wb_adr)
                3'd0:    rdt_d = mtime_q[31:0];
                3'd1:    rdt_d = mtime_q[63:32];
                3'd2:    rdt_d = mtimecmp_q[31:0];
                3'd3:    rdt_d = mtimecmp_q[63:32];
                3'd4:    rdt_d = 32'(pending_q);
                3'd5:    rdt_d = 32'(enable_q);
                3'd6:    rdt_d = 32'(claim_id);
                default: rdt_d = 32'd0;
            endcase
        end
    end

    // Control registers, always reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack_q      <= 1'b0;
            presc_q    <= 16'd0;
            pending_q  <= '0;
            enable_q   <= '0;
            irq_prev_q <= '0;
            mtip_q     <= 1'b0;
            meip_q     <= 1'b0;
`ifdef SERV_IRQ_SYNC_EN
            sync1_q    <= '0;
            sync2_q    <= '0;
`endif
        end else begin
            ack_q      <= ack_d;
            presc_q    <= presc_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            irq_prev_q <= irq_prev_d;
            mtip_q     <= mtip_d;
            meip_q     <= meip_d;
`ifdef SERV_IRQ_SYNC_EN
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
`endif
        end
    end

    generate
        if (RESET_STRATEGY == "NONE") begin : g_dp_noreset
            // Datapath registers without reset
            always_ff @(posedge i_clk) begin
                rdt_q      <= rdt_d;
                mtime_q    <= mtime_d;
                mtimecmp_q <= mtimecmp_d;
            end
        end else begin : g_dp_reset
            // Datapath registers with reset
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    rdt_q      <= 32'd0;
                    mtime_q    <= 64'd0;
                    mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
                end else begin
                    rdt_q      <= rdt_d;
                    mtime_q    <= mtime_d;
                    mtimecmp_q <= mtimecmp_d;
                end
            end
        end
    endgenerate

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;
    assign o_mtip   = mtip_q;
    assign o_meip   = meip_q;

endmodule

// File: tb/tb_serv_irq_source.sv
// Testbench for serv_irq_source (NUM_IRQ=8, PRESCALE=1).
module tb_serv_irq_source;

    localparam int NUM_IRQ = 8;
`ifdef SERV_IRQ_SYNC_EN
    localparam int SYNC_LAT = 3;
`else
    localparam int SYNC_LAT = 1;
`endif

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               cyc = 1'b0;
    logic               we = 1'b0;
    logic [2:0]         adr = 3'd0;
    logic [31:0]        dat = 32'd0;
    logic [3:0]         sel = 4'h0;
    logic [31:0]        o_wb_rdt;
    logic               o_wb_ack;
    logic [NUM_IRQ-1:0] irq = '0;
    logic               o_mtip;
    logic               o_meip;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    serv_irq_source #(
        .NUM_IRQ(NUM_IRQ),
        .PRESCALE(1),
        .RESET_STRATEGY("MINI")
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_wb_cyc(cyc),
        .i_wb_we(we),
        .i_wb_adr(adr),
        .i_wb_dat(dat),
        .i_wb_sel(sel),
        .o_wb_rdt(o_wb_rdt),
        .o_wb_ack(o_wb_ack),
        .i_irq(irq),
        .o_mtip(o_mtip),
        .o_meip(o_meip)
    );

    // Driver tasks: called at #1 after a rising edge, return likewise.
    task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output int lat);
        cyc = 1'b1; we = 1'b0; adr = a; sel = 4'hF; dat = 32'd0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!o_wb_ack && lat < 16);
        d = o_wb_rdt;
        if (!o_wb_ack) begin
            total++; bad++;
            $display("FAIL read_timeout adr=%0d: no ack, required ack within 16 cycles", a);
        end
        cyc = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] v, input logic [3:0] s);
        int lat;
        cyc = 1'b1; we = 1'b1; adr = a; sel = s; dat = v;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!o_wb_ack && lat < 16);
        if (!o_wb_ack) begin
            total++; bad++;
            $display("FAIL write_timeout adr=%0d: no ack, required ack within 16 cycles", a);
        end
        cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_irq(input int b);
        irq[b] = 1'b1;
        @(posedge clk); #1;
        irq[b] = 1'b0;
        repeat (SYNC_LAT + 1) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        logic [31:0] d, e;
        int lat;
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (o_wb_ack !== 1'b0 || o_wb_rdt !== 32'd0 || o_mtip !== 1'b0 || o_meip !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: ack=%b rdt=%h mtip=%b meip=%b, required all 0",
                     o_wb_ack, o_wb_rdt, o_mtip, o_meip);
        end
        rst = 1'b0;
        exp_q.push_back(32'h0);
        bus_read(3'd0, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL reset_mtime_lo: got %h required %h", d, e); end
        total++;
        if (lat !== 1) begin bad++; $display("FAIL ack_latency: got %0d required 1", lat); end
        exp_q.push_back(32'hFFFF_FFFF);
        bus_read(3'd3, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL reset_mtimecmp_hi: got %h required %h", d, e); end
        total++;
        if (o_mtip !== 1'b0 || o_meip !== 1'b0) begin
            bad++; $display("FAIL reset_irq_lines: mtip=%b meip=%b required 0 0", o_mtip, o_meip);
        end
    endtask

    task automatic test_timer;
        logic [31:0] d, e;
        int lat, n;
        bus_write(3'd3, 32'd0, 4'hF);
        bus_write(3'd2, 32'd20, 4'hF);
        bus_write(3'd0, 32'd0, 4'hF);
        // mtime is k at k edges after the write; mtip follows one edge later
        n = 1;
        while (o_mtip !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n !== 21) begin bad++; $display("FAIL mtip_rise: rose after %0d cycles required 21", n); end
        bus_write(3'd2, 32'd1000, 4'hF);
        total++;
        if (o_mtip !== 1'b0) begin bad++; $display("FAIL mtip_fall: got %b required 0", o_mtip); end
        exp_q.push_back(32'd1000);
        bus_read(3'd2, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL mtimecmp_lo: got %h required %h", d, e); end
    endtask

    task automatic test_mtime_carry;
        logic [31:0] d, e;
        int lat;
        bus_write(3'd1, 32'd0, 4'hF);
        bus_write(3'd0, 32'hFFFF_FFFF, 4'hF);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        bus_read(3'd0, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL carry_lo: got %h required %h", d, e); end
        bus_read(3'd1, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL carry_hi: got %h required %h", d, e); end
        // Full write then a byte-1 write two cycles later; each discards its tick
        bus_write(3'd0, 32'h1234_5600, 4'hF);
        bus_write(3'd0, 32'h0000_AB00, 4'b0010);
        exp_q.push_back(32'h1234_AB02);
        bus_read(3'd0, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL tick_write: got %h required %h", d, e); end
    endtask

    task automatic test_irq_claim;
        logic [31:0] d, e;
        int lat;
        bus_write(3'd5, 32'h05, 4'hF);
        pulse_irq(2);
        pulse_irq(0);
        total++;
        if (o_meip !== 1'b1) begin bad++; $display("FAIL meip_set: got %b required 1", o_meip); end
        exp_q.push_back(32'h5);
        bus_read(3'd4, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL pending_5: got %h required %h", d, e); end
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd0);
        for (int k = 0; k < 3; k++) begin
            bus_read(3'd6, d, lat);
            e = exp_q.pop_front();
            total++;
            if (d !== e) begin bad++; $display("FAIL claim_%0d: got %h required %h", k, d, e); end
            if (k == 1) begin
                total++;
                if (o_meip !== 1'b0) begin bad++; $display("FAIL meip_clear: got %b required 0", o_meip); end
            end
        end
    endtask

    task automatic test_edge_latency;
        logic [31:0] d, e;
        int lat, n;
        bus_write(3'd5, 32'h02, 4'hF);
        irq[1] = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (o_meip !== 1'b1 && n < 20);
        total++;
        if (n !== SYNC_LAT + 1) begin
            bad++; $display("FAIL edge_latency: meip after %0d cycles required %0d", n, SYNC_LAT + 1);
        end
        exp_q.push_back(32'h2);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'h0);
        bus_read(3'd4, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL pending_src1: got %h required %h", d, e); end
        bus_read(3'd6, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL claim_src1: got %h required %h", d, e); end
        bus_read(3'd4, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL level_no_reedge: got %h required %h", d, e); end
        irq[1] = 1'b0;
        repeat (SYNC_LAT + 1) begin @(posedge clk); #1; end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d, e;
        logic [5:0] pat;
        int lat;
        cyc = 1'b1; we = 1'b1; adr = 3'd5; dat = 32'hFFFF_FFFF; sel = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            pat[k] = o_wb_ack;
        end
        cyc = 1'b0; we = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        total++;
        if (pat !== 6'b010101) begin bad++; $display("FAIL held_cyc_acks: got %b required 010101", pat); end
        exp_q.push_back(32'hFF);
        bus_read(3'd5, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL enable_ff: got %h required %h", d, e); end
        bus_write(3'd5, 32'h0, 4'b1110);
        exp_q.push_back(32'hFF);
        bus_read(3'd5, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL enable_bytesel: got %h required %h", d, e); end
        bus_write(3'd7, 32'hFFFF_FFFF, 4'hF);
        exp_q.push_back(32'h0);
        bus_read(3'd7, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL reserved_addr: got %h required %h", d, e); end
    endtask

    task automatic test_w1c;
        logic [31:0] d, e;
        int lat;
        pulse_irq(0);
        exp_q.push_back(32'h1);
        bus_read(3'd4, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL w1c_pre: got %h required %h", d, e); end
        bus_write(3'd4, 32'hFF, 4'b1110);
        exp_q.push_back(32'h1);
        bus_read(3'd4, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL w1c_unselected: got %h required %h", d, e); end
        bus_write(3'd4, 32'h1, 4'hF);
        exp_q.push_back(32'h0);
        bus_read(3'd4, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL w1c_clear: got %h required %h", d, e); end
        // Time the write so the clear and the new edge land on the same edge
        irq[0] = 1'b1;
        repeat (SYNC_LAT - 1) begin @(posedge clk); #1; end
        bus_write(3'd4, 32'h1, 4'hF);
        irq[0] = 1'b0;
        exp_q.push_back(32'h1);
        bus_read(3'd4, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL w1c_set_wins: got %h required %h", d, e); end
    endtask

    task automatic test_reset_mid_access;
        logic [31:0] d, e;
        int lat;
        cyc = 1'b1; we = 1'b1; adr = 3'd5; dat = 32'h0F; sel = 4'hF;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (o_wb_ack !== 1'b0) begin bad++; $display("FAIL reset_mid_ack: got %b required 0", o_wb_ack); end
        cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(32'h0);
        bus_read(3'd5, d, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL reset_mid_write_lost: got %h required %h", d, e); end
    endtask

    initial begin
        test_reset();
        test_timer();
        test_mtime_carry();
        test_irq_claim();
        test_edge_latency();
        test_back_to_back();
        test_w1c();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
